// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   Sits beside the ALU as the iterative divide unit of the CPU datapath.
//
//   A launch seen while idle latches the operands and runs WIDTH shift/subtract
//   iterations (busy high for exactly WIDTH cycles). A zero divisor is resolved
//   in the launch cycle: quotient = all ones, remainder = dividend, and
//   div_by_zero is raised. Results hold until the next accepted launch or reset.
//
//   Optional feature (macro DIVIDER_DONE_PULSE_EN): adds a registered one-cycle
//   'done' pulse in the cycle after a result becomes valid (normal completion
//   or immediate divide-by-zero completion).
//
// Parameters:
//   WIDTH        operand / result width (>= 2)
//
// Ports:
//   clk          clock, rising-edge
//   reset        synchronous active-high reset, priority over launch
//   launch       start request, honoured only while busy = 0
//   dividend     unsigned dividend, sampled on the accepted launch edge
//   divisor      unsigned divisor, sampled on the accepted launch edge
//   busy         high while iterating
//   div_by_zero  last accepted launch had divisor == 0
//   quotient     result quotient, valid while busy = 0
//   remainder    result remainder, valid while busy = 0
//   done         (DIVIDER_DONE_PULSE_EN only) one-cycle completion pulse
// ----------------------------------------------------------------------------
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             launch,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIVIDER_DONE_PULSE_EN
    ,
    output logic             done
`endif
);

    // Iteration counter only needs to reach WIDTH-1.
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned EXT_W = WIDTH + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 dbz_q, dbz_d;
    logic                 busy_q, busy_d;

    logic [EXT_W-1:0]     shifted;
    logic [EXT_W-1:0]     trial;
    logic                 fits;
    logic                 last_iter;

    // Trial subtraction on the shifted partial remainder. Because the partial
    // remainder is always below the divisor, the shifted value is below twice
    // the divisor, so the MSB of the WIDTH+1-bit difference is a clean borrow.
    always_comb begin
        shifted   = {rem_q, quo_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvsr_q};
        fits      = ~trial[EXT_W-1];
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    if (divisor == '0) begin
                        // Resolved immediately; no iterations.
                        dbz_d = 1'b1;
                        quo_d = '1;
                        rem_d = dividend;
                    end else begin
                        dbz_d   = 1'b0;
                        quo_d   = dividend;
                        rem_d   = '0;
                        dvsr_d  = divisor;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                // Shift {remainder, quotient} left; new quotient LSB is the
                // outcome of the trial subtraction.
                quo_d = {quo_q[WIDTH-2:0], fits};
                rem_d = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                if (last_iter) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef DIVIDER_DONE_PULSE_EN
    // Pulse follows the edge at which a result becomes valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= ((state_q == RUN) && last_iter) ||
                    ((state_q == IDLE) && launch && (divisor == '0));
        end
    end
`endif

    assign busy        = busy_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
//   Directed and exhaustive self-checking bench for seq_divider (WIDTH = 4).
//   Expected results come from integer division in the bench and are queued
//   at launch time, then popped when the divider reports completion.
//   Honours DIVIDER_DONE_PULSE_EN when the design is built with it.
// ----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         launch;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         div_by_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
`ifdef DIVIDER_DONE_PULSE_EN
    logic         done;
    int           done_cycles = 0;
`endif

    int   checks      = 0;
    int   failures    = 0;
    int   completions = 0;
    exp_t sb[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .launch      (launch),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
`ifdef DIVIDER_DONE_PULSE_EN
        ,
        .done        (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIVIDER_DONE_PULSE_EN
    always @(posedge clk) if (done === 1'b1) done_cycles++;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = W'(int'(a) / int'(b));
            e.r   = W'(int'(a) % int'(b));
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Waits (bounded) for busy to drop; returns edges counted since launch.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 4 * W) begin
            tick();
            n++;
        end
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_q"},   32'(quotient),    32'(e.q));
        check({tag, "_r"},   32'(remainder),   32'(e.r));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
`ifdef DIVIDER_DONE_PULSE_EN
        check({tag, "_done"}, 32'(done), 32'd1);
`endif
        completions++;
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        sb.push_back(model(a, b));
        dividend = a;
        divisor  = b;
        launch   = 1'b1;
        tick();
        launch   = 1'b0;
        if (b == '0) begin
            check({tag, "_busy0"}, 32'(busy), 32'd0);
        end else begin
            check({tag, "_busy1"}, 32'(busy), 32'd1);
            check({tag, "_dbz0"},  32'(div_by_zero), 32'd0);
            wait_idle(n);
            check({tag, "_latency"}, 32'(n), 32'(W));
        end
        compare_result(tag);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        launch   = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy),        32'd0);
        check("rst_dbz",  32'(div_by_zero), 32'd0);
        check("rst_q",    32'(quotient),    32'd0);
        check("rst_r",    32'(remainder),   32'd0);

        do_op("d7_3", 4'd7, 4'd3);
        do_op("d7_0", 4'd7, 4'd0);
        do_op("d15_1", 4'd15, 4'd1);
        do_op("d2_5", 4'd2, 4'd5);

        // Launch during busy is ignored; reset on 2nd RUN edge aborts.
        dividend = 4'd13;
        divisor  = 4'd4;
        launch   = 1'b1;
        tick();
        launch   = 1'b0;
        check("abort_busy1", 32'(busy), 32'd1);
        dividend = 4'd9;
        divisor  = 4'd2;
        launch   = 1'b1;
        tick();
        launch   = 1'b0;
        check("ignored_launch_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy),        32'd0);
        check("abort_dbz",  32'(div_by_zero), 32'd0);
        check("abort_q",    32'(quotient),    32'd0);
        check("abort_r",    32'(remainder),   32'd0);
        do_op("d13_4", 4'd13, 4'd4);

        // Divide-by-zero flag is cleared by reset.
        do_op("d5_0", 4'd5, 4'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_dbz", 32'(div_by_zero), 32'd0);

        // Launch held high: next op accepted on first edge with busy = 0.
        dividend = 4'd6;
        divisor  = 4'd2;
        launch   = 1'b1;
        sb.push_back(model(4'd6, 4'd2));
        sb.push_back(model(4'd6, 4'd2));
        tick();
        check("hold_busy1", 32'(busy), 32'd1);
        wait_idle(n);
        check("hold_latency", 32'(n), 32'(W));
        compare_result("hold_first");
        tick();
        launch = 1'b0;
        check("hold_reaccept", 32'(busy), 32'd1);
        wait_idle(n);
        check("hold_latency2", 32'(n), 32'(W));
        compare_result("hold_second");

        // Exhaustive sweep, with algebraic check on nonzero divisors.
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                do_op("sweep", W'(a), W'(b));
                if (b != 0) begin
                    check("sweep_identity", 32'(int'(quotient) * b + int'(remainder)), 32'(a));
                    check("sweep_rem_lt", 32'(int'(remainder) < b), 32'd1);
                end
            end
        end

        tick();
        tick();
`ifdef DIVIDER_DONE_PULSE_EN
        check("done_pulse_count", 32'(done_cycles), 32'(completions));
`endif
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
